// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult (5) / div (10) sequencing with HI/LO registers.
// Optional signed multiply-accumulate (md_op=4) is enabled by defining MDU_MADD_EN.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd4;
`endif

  logic [1:0]  state_r;
  logic [3:0]  count_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic [63:0] res_s;
  logic        res_we_s;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_legal = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:                            op_legal = 1'b1;
`endif
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Low 64 bits of the product are identical for signed and unsigned once operands are extended.
  function automatic logic [63:0] mul_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    ext_a = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    mul_result = ext_a * ext_b;
  endfunction

  // Signed division via magnitudes: quotient truncates to zero, remainder follows the dividend.
  // This also makes 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
  function automatic logic [63:0] div_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (neg_a ^ neg_b) begin
      q = ~q + 32'd1;
    end else begin
      q = q;
    end
    if (neg_a) begin
      r = ~r + 32'd1;
    end else begin
      r = r;
    end
    div_result = {r, q};
  endfunction

  // Result selection for the latched operation; a zero divisor suppresses the write.
  always_comb begin
    res_s    = 64'd0;
    res_we_s = 1'b0;
    case (op_r)
      OP_MULT: begin
        res_s    = mul_result(a_r, b_r, 1'b1);
        res_we_s = 1'b1;
      end
      OP_MULTU: begin
        res_s    = mul_result(a_r, b_r, 1'b0);
        res_we_s = 1'b1;
      end
      OP_DIV: begin
        res_s    = div_result(a_r, b_r, 1'b1);
        res_we_s = (b_r != 32'd0);
      end
      OP_DIVU: begin
        res_s    = div_result(a_r, b_r, 1'b0);
        res_we_s = (b_r != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res_s    = {hi_r, lo_r} + mul_result(a_r, b_r, 1'b1);
        res_we_s = 1'b1;
      end
`endif
      default: begin
        res_s    = 64'd0;
        res_we_s = 1'b0;
      end
    endcase
  end

  // Sequencer, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      op_r    <= 3'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (op_legal(md_op)) begin
              a_r     <= A;
              b_r     <= B;
              op_r    <= md_op;
              state_r <= op_is_div(md_op) ? DIV : MULT;
              count_r <= op_is_div(md_op) ? 4'd10 : 4'd5;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            if (mthi) begin
              hi_r <= A;
            end
            if (mtlo) begin
              lo_r <= A;
            end
          end
        end
        MULT, DIV: begin
          if (count_r == 4'd1) begin
            if (res_we_s) begin
              hi_r <= res_s[63:32];
              lo_r <= res_s[31:0];
            end
            state_r <= IDLE;
            count_r <= 4'd0;
            busy_r  <= 1'b0;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign stall = md_use_D & (start | busy_r);
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed ops push expected HI/LO and busy length,
// a negedge monitor pops and compares whenever busy falls.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        mthi;
  logic        mtlo;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .md_use_D(md_use_D),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          ncyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cnt = 0;
  logic busy_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t x;
    x.hi = h;
    x.lo = l;
    x.ncyc = n;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle t; returns in cycle t+1 with start dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    step();
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 30) begin
      step();
      k++;
    end
    chk(name, {31'd0, busy}, 32'd0);
    step();
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] v);
    mthi = h;
    mtlo = l;
    A = v;
    step();
    mthi = 1'b0;
    mtlo = 1'b0;
  endtask

  // Monitor: every busy falling edge retires one scoreboard entry.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (busy_prev === 1'b1 && busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: completion with hi=0x%08h lo=0x%08h, nothing expected", hi, lo);
      end else begin
        e = exp_q.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_busy_cycles", busy_cnt, e.ncyc);
      end
      busy_cnt = 0;
    end
    busy_prev = busy;
  end

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; md_use_D = 1'b0;
    step();
    // Stall stays combinational through reset.
    start = 1'b1; md_use_D = 1'b1;
    #1;
    chk("stall_in_reset", {31'd0, stall}, 32'd1);
    step();
    start = 1'b0;
    reset = 1'b0;
    #1;
    chk("stall_idle", {31'd0, stall}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    md_use_D = 1'b0;

    push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle("mult_done");

    push(32'h00000001, 32'hFFFFFFFE, 5);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu_done");

    push(32'd1, 32'd3, 10);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle("divu_done");

    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg_dividend");

    push(32'd1, 32'hFFFFFFFD, 10);
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    wait_idle("div_neg_divisor");

    push(32'd0, 32'h80000000, 10);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_overflow");

    push(32'h80000000, 32'd0, 10);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divu_big");

    mt(1'b1, 1'b0, 32'h1234);
    chk("mthi", hi, 32'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    chk("mtlo", lo, 32'h5678);
    push(32'h1234, 32'h5678, 10);
    issue(3'd2, 32'd5, 32'd0);
    wait_idle("div_by_zero");

    // Second start and mtlo during a mult are ignored; stall follows busy.
    md_use_D = 1'b1;
    push(32'd0, 32'd15, 5);
    issue(3'd0, 32'd3, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) begin
        start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7; mtlo = 1'b1;
      end
      #1;
      chk("stall_busy", {31'd0, stall}, 32'd1);
      chk("busy_window", {31'd0, busy}, 32'd1);
      step();
      start = 1'b0;
      mtlo = 1'b0;
    end
    #1;
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("stall_after", {31'd0, stall}, 32'd0);
    md_use_D = 1'b0;
    step();

    mt(1'b1, 1'b1, 32'hCAFEF00D);
    chk("mt_both_hi", hi, 32'hCAFEF00D);
    chk("mt_both_lo", lo, 32'hCAFEF00D);

    start = 1'b1; md_op = 3'd5; A = 32'd1; B = 32'd1;
    step();
    start = 1'b0;
    chk("reserved_busy", {31'd0, busy}, 32'd0);
    step();
    chk("reserved_busy2", {31'd0, busy}, 32'd0);
    chk("reserved_hi", hi, 32'hCAFEF00D);
    chk("reserved_lo", lo, 32'hCAFEF00D);

    mt(1'b1, 1'b0, 32'd0);
    mt(1'b0, 1'b1, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    push(32'd1, 32'd0, 5);
    issue(3'd4, 32'd1, 32'd1);
    wait_idle("madd_done");
`else
    start = 1'b1; md_op = 3'd4; A = 32'd1; B = 32'd1;
    step();
    start = 1'b0;
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    chk("madd_off_busy2", {31'd0, busy}, 32'd0);
    chk("madd_off_hi", hi, 32'd0);
    chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

    // Reset in cycle t+4 of a div aborts it with no write.
    mt(1'b1, 1'b1, 32'h0000AAAA);
    push(32'd0, 32'd0, 4);
    issue(3'd2, 32'd100, 32'd7);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);
    chk("abort_late_busy", {31'd0, busy}, 32'd0);

    step();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  E-stage mult/div issue strobe.
REQ-004 SHALL have: md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd (macro only), others reserved.
REQ-005 SHALL have: A  in  32  rs operand; B  in  32  rt operand.
REQ-006 SHALL have: mthi  in  1  and  mtlo  in  1  write A into HI / LO.
REQ-007 SHALL have: md_use_D  in  1  D-stage instruction needs the MDU (mult/div/mf/mt/madd).
REQ-008 SHALL have: busy  out  1;  stall  out  1;  hi  out  32;  lo  out  32.

Function
REQ-009 SHALL implement FSM states IDLE, MULT and DIV plus a 4-bit down-counter.
REQ-010 SHALL, in IDLE with start=1 and a legal md_op, latch A, B and md_op, then enter MULT with count 5 or DIV with count 10.
REQ-011 SHALL drive busy=1 exactly in cycles t+1..t+N for a start sampled in cycle t, with N=5 for mult and N=10 for div.
REQ-012 SHALL write HI/LO on the edge closing cycle t+N, return to IDLE and drop busy in cycle t+N+1.
REQ-013 SHALL compute mult/multu as a 64-bit signed/unsigned product: HI = product[63:32], LO = product[31:0].
REQ-014 SHALL compute div/divu as LO = quotient, HI = remainder; signed quotient truncates toward zero and remainder takes the dividend's sign.
REQ-015 SHALL give 0x80000000 / 0xFFFFFFFF (signed) LO=0x80000000, HI=0.
REQ-016 SHALL leave HI/LO unchanged when the divisor is zero; the busy timing stays 10 cycles.
REQ-017 SHALL ignore start while busy=1 (no re-latch, no counter restart).
REQ-018 SHALL ignore start with a reserved md_op; the FSM stays IDLE.
REQ-019 SHALL write HI (mthi) or LO (mtlo) on the next edge only when in IDLE and start=0.
REQ-020 SHALL ignore mthi/mtlo when start=1 or busy=1.
REQ-021 SHALL, with mthi and mtlo both high, write both registers from A.
REQ-022 SHALL drive stall = md_use_D & (start | busy), combinationally, with no added latency.
REQ-023 SHALL drive hi/lo directly from the registers, changing only on the edges defined above.

Reset
REQ-024 SHALL on reset=1 at a clock edge set state IDLE, counter 0, HI=0, LO=0, busy=0, and clear the latched operands.
REQ-025 SHALL abort an in-flight operation on reset with no HI/LO update; reset takes priority over start and mthi/mtlo.
REQ-026 SHALL keep stall combinational during reset, so stall = md_use_D & start.

Configuration
REQ-027 SHALL honour macro MDU_MADD_EN.
REQ-028 SHALL, with MDU_MADD_EN defined, accept md_op=4 (madd) with N=5 and set {HI,LO} = {HI,LO} + signed(A)*signed(B) mod 2^64, using the HI/LO values at the completion edge.
REQ-029 SHALL, without MDU_MADD_EN, treat md_op=4 as reserved per REQ-018 and synthesize no accumulator adder.

Verification
REQ-030 SHALL cover: start, mult, A=0xFFFFFFFE, B=3 -> busy cycles t+1..t+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 SHALL cover: start, divu, A=7, B=2 -> busy for 10 cycles; then HI=1, LO=3; signed div A=-7, B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-032 SHALL cover: div with B=0 after mthi A=0x1234, mtlo A=0x5678 -> busy for 10 cycles; HI=0x1234, LO=0x5678 unchanged.
REQ-033 SHALL cover: second start and an mtlo issued at cycle t+3 of a mult -> both ignored; mult result written at t+5; with md_use_D=1 during busy -> stall=1 every busy cycle.
REQ-034 SHALL cover: reset asserted at cycle t+4 of a div -> HI=LO=0, busy=0 next cycle; no later write.
REQ-035 SHALL cover: with MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0; without the macro, the same stimulus -> busy stays 0 and HI/LO unchanged.
